gate_input_debounce: RTL and testbench



---
 rtl/gate_db_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 123 ++++++++++++
 rtl/gate_input_debounce.sv | 67 ++++++
 tb/tb_gate_input_debounce.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_db_pkg.sv
// ============================================================================
// Module      : gate_db_pkg
// Description : Shared state encoding and defaults for the gate input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_db_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : Two-flop synchroniser plus counter FSM debouncing one raw level.
//               GATE_DEBOUNCE_EDGE_EN adds registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import gate_db_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic waiting
`ifdef GATE_DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Counter is held (not incremented) once it reaches the compare value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      STABLE_LO: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt = STABLE_HI;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt = STABLE_LO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
  end

  assign level   = r_level;
  assign waiting = (r_state == WAIT_HI) || (r_state == WAIT_LO);

`ifdef GATE_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses land on the same edge as the level change they mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_level_nxt & ~r_level;
      r_fall <= ~w_level_nxt & r_level;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`endif

endmodule

`default_nettype wire

// File: rtl/gate_input_debounce.sv
// ============================================================================
// Module      : gate_input_debounce
// Description : Synchronises and debounces two raw switch levels for a gate.
//               GATE_DEBOUNCE_EDGE_EN adds A/B rise and fall pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_input_debounce
  import gate_db_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A_raw,
  input  logic B_raw,
  output logic A,
  output logic B,
  output logic busy
`ifdef GATE_DEBOUNCE_EDGE_EN
  ,
  output logic A_rise,
  output logic A_fall,
  output logic B_rise,
  output logic B_fall
`endif
);

  logic w_wait_a;
  logic w_wait_b;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (A_raw),
    .level  (A),
    .waiting(w_wait_a)
`ifdef GATE_DEBOUNCE_EDGE_EN
    ,
    .rise   (A_rise),
    .fall   (A_fall)
`endif
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (B_raw),
    .level  (B),
    .waiting(w_wait_b)
`ifdef GATE_DEBOUNCE_EDGE_EN
    ,
    .rise   (B_rise),
    .fall   (B_fall)
`endif
  );

  assign busy = w_wait_a | w_wait_b;

endmodule

`default_nettype wire

// File: tb/tb_gate_input_debounce.sv
// ============================================================================
// Module      : tb_gate_input_debounce
// Description : Self-checking bench for gate_input_debounce, DEBOUNCE_CYCLES=4.
//               Define GATE_DEBOUNCE_EDGE_EN to also exercise the edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_input_debounce;

  logic clk;
  logic rst_n;
  logic A_raw;
  logic B_raw;
  logic A;
  logic B;
  logic busy;
`ifdef GATE_DEBOUNCE_EDGE_EN
  logic A_rise;
  logic A_fall;
  logic B_rise;
  logic B_fall;
`endif

  typedef struct {
    int         k;
    logic       a;
    logic       b;
    logic       busy;
    logic [3:0] edges;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  gate_input_debounce #(
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A_raw(A_raw),
    .B_raw(B_raw),
    .A    (A),
    .B    (B),
    .busy (busy)
`ifdef GATE_DEBOUNCE_EDGE_EN
    ,
    .A_rise(A_rise),
    .A_fall(A_fall),
    .B_rise(B_rise),
    .B_fall(B_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns with reset released, raw inputs low, 1 ns after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    A_raw = 1'b0;
    B_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    A_raw = 1'b1;
    B_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{i, 1'b0, 1'b0, 1'b0, 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sb.push_back('{k, k >= 7, k >= 7, (k >= 3) && (k <= 6), 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL reset_release edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

  task automatic test_clean_step();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      A_raw = (k <= 12);
      B_raw = 1'b0;
      // Rise sampled at edge 1, fall sampled at edge 13.
      sb.push_back('{k, (k >= 7) && (k < 19), 1'b0,
                     ((k >= 3) && (k <= 6)) || ((k >= 15) && (k <= 18)), 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL clean_step edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic ra;
    logic ebusy;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      // Pulses of 3, 4 and 5 cycles starting at edges 1, 10 and 20.
      ra = ((k >= 1) && (k <= 3)) || ((k >= 10) && (k <= 13)) || ((k >= 20) && (k <= 24));
      ebusy = ((k >= 3) && (k <= 5)) || ((k >= 12) && (k <= 15)) ||
              ((k >= 22) && (k <= 25)) || ((k >= 27) && (k <= 30));
      A_raw = ra;
      B_raw = 1'b0;
      sb.push_back('{k, (k >= 26) && (k <= 30), 1'b0, ebusy, 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL glitch edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [5:0] pat;
    logic ebusy;
    pat = 6'b101101;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      A_raw = (k <= 6) ? pat[k-1] : 1'b1;
      B_raw = 1'b0;
      ebusy = (k == 3) || (k == 5) || (k == 6) || ((k >= 8) && (k <= 11));
      // Final 0->1 sample is edge 6, so the level rises on edge 12.
      sb.push_back('{k, k >= 12, 1'b0, ebusy, 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL bounce edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      A_raw = 1'b1;
      B_raw = 1'b1;
      sb.push_back('{k, k >= 7, k >= 7, (k >= 3) && (k <= 6), 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL simultaneous edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      A_raw = 1'b1;
      B_raw = 1'b1;
      sb.push_back('{k, 1'b0, 1'b0, k >= 3, 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL mid_reset_pre edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
    // Asynchronous assertion: must clear without a clock edge.
    rst_n = 1'b0;
    sb.push_back('{5, 1'b0, 1'b0, 1'b0, 4'b0});
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
      n_err++;
      $display("FAIL mid_reset_async after edge %0d: A,B,busy=%b%b%b want %b%b%b",
               e.k, A, B, busy, e.a, e.b, e.busy);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{i, 1'b0, 1'b0, 1'b0, 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL mid_reset_hold cycle %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sb.push_back('{k, k >= 7, k >= 7, (k >= 3) && (k <= 6), 4'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if ({A, B, busy} !== {e.a, e.b, e.busy}) begin
        n_err++;
        $display("FAIL mid_reset_resume edge %0d: A,B,busy=%b%b%b want %b%b%b",
                 e.k, A, B, busy, e.a, e.b, e.busy);
      end
    end
  endtask

`ifdef GATE_DEBOUNCE_EDGE_EN
  task automatic test_edges();
    exp_t e;
    logic [3:0] got;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      A_raw = (k <= 10);
      B_raw = 1'b0;
      // Rise on edge 7, fall sampled at edge 11 lands on edge 17.
      sb.push_back('{k, (k >= 7) && (k < 17), 1'b0, 1'b0,
                     {k == 7, k == 17, 1'b0, 1'b0}});
      @(posedge clk); #1;
      e = sb.pop_front();
      got = {A_rise, A_fall, B_rise, B_fall};
      n_vec++;
      if ({A, B, got} !== {e.a, e.b, e.edges}) begin
        n_err++;
        $display("FAIL edges edge %0d: A,B,rise/fall=%b%b %b want %b%b %b",
                 e.k, A, B, got, e.a, e.b, e.edges);
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    A_raw = 1'b0;
    B_raw = 1'b0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
`ifdef GATE_DEBOUNCE_EDGE_EN
    test_edges();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
